// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fetch_pkg -- fetch FSM state encoding and default geometry.   Rev 1.0
//==============================================================================
package fetch_pkg;

    localparam int DEFAULT_AW    = 8;
    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// sync_fifo -- power-of-two synchronous FIFO with occupancy count.   Rev 1.0
//==============================================================================
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

    overflow_check: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// fetch_buffer -- credit-limited prefetcher from synchronous memory.   Rev 1.0
//==============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] addr_in,
    output logic          addr_adv,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic             inflight;
    logic [AW-1:0]    addr_q;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    occupancy;
    logic             fifo_empty;
    logic             issue;
    logic             pop;
    logic [DW+AW-1:0] head;

    // Every issued read owns a FIFO slot until it is popped.
    assign occupancy = fifo_count + {{(CW-1){1'b0}}, inflight};
    assign issue     = (state == RUN) && !stop && (occupancy < CW'(DEPTH));

    assign mem_rd   = issue;
    assign addr_adv = issue;
    assign mem_addr = issue ? addr_in : addr_q;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = RUN;
            RUN:     if (stop) state_nxt = DRAIN;
            DRAIN:   if (!inflight && fifo_count == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addr_q doubles as the tag of the word in flight during the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            addr_q   <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) addr_q <= addr_in;
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW + AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data ({addr_q, mem_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign out_addr = out_valid ? head[DW+AW-1:DW] : '0;
    assign out_data = out_valid ? head[DW-1:0]     : '0;
    assign out_last = out_valid && (&head[DW+AW-1:DW]);

endmodule
`default_nettype wire
